// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame geometry, receive states
// and the parity check used by the deframer.
package uart_pkg;

  localparam int         UART_FRAME_BITS = 11;
  localparam logic [1:0] PAR_NONE        = 2'b00;
  localparam logic [1:0] PAR_ODD         = 2'b01;
  localparam logic [1:0] PAR_EVEN        = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // True when the received parity slot disagrees with the configured scheme.
  function automatic logic parity_mismatch(input logic [1:0] setting,
                                           input logic [7:0] data,
                                           input logic       p);
    case (setting)
      PAR_ODD:  return p != ~^data;
      PAR_EVEN: return p != ^data;
      PAR_NONE: return 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter for the UART receiver; ticks at the half-period (start
// bit centre) or at the full period, and restarts whenever clr is high.
module uart_rx_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        half_sel,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] target_s;

  // Compare point and next count.
  always_comb begin
    target_s = half_sel ? ((period >> 1) - 32'd1) : (period - 32'd1);
    tick     = (cnt_q == target_s);
    cnt_d    = clr ? 32'd0 : (cnt_q + 32'd1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx_data, centre-samples the 11-bit frame
// and presents each byte with parity/framing status on a 1-cycle strobe.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_data,
  input  logic [1:0]           cfg_parity_setting,
  input  logic [31:0]          cfg_clkSpeed_over_bdRate,
  output logic [DATA_BITS-1:0] rx_data_word,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 4);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [31:0]          period_q, period_d;
  logic [1:0]           par_q, par_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 tick_s, clr_s, half_sel_s;

  // The counter idles cleared and restarts after every sample point.
  assign clr_s      = tick_s | (state_q == IDLE) | (state_q == BREAK);
  assign half_sel_s = (state_q == START);

  uart_rx_bit_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .half_sel (half_sel_s),
    .period   (period_q),
    .tick     (tick_s)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    par_d      = par_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    perr_d     = perr_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d  = START;
          period_d = (cfg_clkSpeed_over_bdRate < 32'(MIN_PERIOD)) ?
                     32'(MIN_PERIOD) : cfg_clkSpeed_over_bdRate;
          par_d    = cfg_parity_setting;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_d   = rx_s_q ? IDLE : DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = (bit_idx_q == LAST_BIT) ? PARITY : DATA;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          perr_d  = parity_mismatch(par_q, shreg_q, rx_s_q);
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          word_d     = shreg_q;
          valid_d    = 1'b1;
          perr_out_d = perr_q;
          ferr_d     = ~rx_s_q;
          state_d    = rx_s_q ? IDLE : BREAK;
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        // A held-low line must return high before a new start is recognised.
        if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      period_q   <= 32'd0;
      par_q      <= 2'b00;
      shreg_q    <= '0;
      bit_idx_q  <= 3'd0;
      perr_q     <= 1'b0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_data;
      rx_s_q     <= sync1_q;
      period_q   <= period_d;
      par_q      <= par_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      perr_q     <= perr_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data_word  = word_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_out_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed cases plus random frames
// checked against a frame-level reference model.
module tb_uart_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_data = 1'b1;
  logic [1:0]  cfg_parity_setting = 2'b00;
  logic [31:0] cfg_clkSpeed_over_bdRate = 32'd16;
  logic [7:0]  rx_data_word;
  logic        rx_valid, rx_parity_err, rx_frame_err, rx_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] t;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
  } strobe_t;
  strobe_t sq[$];

  uart_rx_deframer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .rx_data                  (rx_data),
    .cfg_parity_setting       (cfg_parity_setting),
    .cfg_clkSpeed_over_bdRate (cfg_clkSpeed_over_bdRate),
    .rx_data_word             (rx_data_word),
    .rx_valid                 (rx_valid),
    .rx_parity_err            (rx_parity_err),
    .rx_frame_err             (rx_frame_err),
    .rx_busy                  (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which the strobe is seen high.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) sq.push_back('{32'(cyc), rx_data_word, rx_parity_err, rx_frame_err});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_n(input logic [31:0] c);
    return (c < 32'd4) ? 4 : int'(c);
  endfunction

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit a correct transmitter would place in the slot.
  function automatic logic good_p(input logic [1:0] s, input logic [7:0] d);
    if (s == 2'b01) return (ones(d) % 2 == 0);
    if (s == 2'b10) return (ones(d) % 2 == 1);
    return 1'b0;
  endfunction

  function automatic logic exp_perr(input logic [1:0] s, input logic [7:0] d, input logic p);
    if (s == 2'b01 || s == 2'b10) return p != good_p(s, d);
    return 1'b0;
  endfunction

  function automatic int exp_time(input int t_fall, input int n);
    return t_fall + 10 * n + n / 2 + 3;
  endfunction

  // Drive the first nbits of a frame; cfg is scrambled once the frame is under way.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic [31:0] cfg, input logic [1:0] set,
                            input int nbits, output int t_fall);
    logic [10:0] bits;
    int n;
    bits = {stop, p, d, 1'b0};
    n = eff_n(cfg);
    cfg_clkSpeed_over_bdRate = cfg;
    cfg_parity_setting = set;
    t_fall = cyc;
    for (int b = 0; b < nbits; b++) begin
      rx_data = bits[b];
      if (b == 1) begin
        cfg_clkSpeed_over_bdRate = $urandom;
        cfg_parity_setting = 2'($urandom);
      end
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic expect_strobe(input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input int t_exp, output int t_got);
    strobe_t s;
    int w = 0;
    t_got = -1;
    while (sq.size() == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_present"}, 32'(sq.size() > 0), 32'd1);
    if (sq.size() > 0) begin
      s = sq.pop_front();
      t_got = int'(s.t);
      chk({tag, "_data"}, 32'(s.d), 32'(d));
      chk({tag, "_perr"}, 32'(s.pe), 32'(pe));
      chk({tag, "_ferr"}, 32'(s.fe), 32'(fe));
      chk({tag, "_time"}, s.t, 32'(t_exp));
    end
  endtask

  initial begin
    int tf, tf2, tg, tg2, n, gap;
    logic [7:0] d;
    logic [1:0] set;
    logic [31:0] cfg;
    logic p;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_word", 32'(rx_data_word), 32'd0);
    chk("rst_perr", 32'(rx_parity_err), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain frame, no parity.
    send_frame(8'h55, 1'b0, 1'b1, 32'd16, 2'b00, 11, tf);
    expect_strobe("t1", 8'h55, 1'b0, 1'b0, exp_time(tf, 16), tg);
    chk("t1_latency", 32'(tg - tf), 32'd171);
    repeat (4) @(negedge clk);

    // Even parity, wrong then right slot.
    send_frame(8'hA7, 1'b0, 1'b1, 32'd16, 2'b10, 11, tf);
    expect_strobe("t2a", 8'hA7, exp_perr(2'b10, 8'hA7, 1'b0), 1'b0, exp_time(tf, 16), tg);
    chk("t2a_err_set", 32'(exp_perr(2'b10, 8'hA7, 1'b0)), 32'd1);
    send_frame(8'hA7, 1'b1, 1'b1, 32'd16, 2'b10, 11, tf);
    expect_strobe("t2b", 8'hA7, 1'b0, 1'b0, exp_time(tf, 16), tg);
    repeat (4) @(negedge clk);

    // Short low glitch on an idle line.
    cfg_clkSpeed_over_bdRate = 32'd16;
    cfg_parity_setting = 2'b00;
    rx_data = 1'b0;
    repeat (3) @(negedge clk);
    rx_data = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_busy_hi", 32'(rx_busy), 32'd1);
    repeat (8) @(negedge clk);
    chk("t3_busy_lo", 32'(rx_busy), 32'd0);
    chk("t3_no_strobe", 32'(sq.size()), 32'd0);

    // Bad stop bit followed by a long low line.
    send_frame(8'h3C, 1'b0, 1'b0, 32'd16, 2'b00, 11, tf);
    repeat (40) @(negedge clk);
    chk("t4_busy_break", 32'(rx_busy), 32'd1);
    expect_strobe("t4", 8'h3C, 1'b0, 1'b1, exp_time(tf, 16), tg);
    chk("t4_single", 32'(sq.size()), 32'd0);
    rx_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_busy_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 32'd16, 2'b00, 11, tf);
    expect_strobe("t4b", 8'h12, 1'b0, 1'b0, exp_time(tf, 16), tg);
    repeat (4) @(negedge clk);

    // Back-to-back frames at an odd period.
    send_frame(8'h01, 1'b0, 1'b1, 32'd5, 2'b00, 11, tf);
    send_frame(8'hFE, 1'b0, 1'b1, 32'd5, 2'b00, 11, tf2);
    expect_strobe("t5a", 8'h01, 1'b0, 1'b0, exp_time(tf, 5), tg);
    expect_strobe("t5b", 8'hFE, 1'b0, 1'b0, exp_time(tf2, 5), tg2);
    chk("t5_spacing", 32'(tg2 - tg), 32'd55);
    repeat (4) @(negedge clk);

    // Reset in the middle of the data bits.
    send_frame(8'h99, 1'b0, 1'b1, 32'd16, 2'b00, 4, tf);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(rx_valid), 32'd0);
    chk("t6_word", 32'(rx_data_word), 32'd0);
    chk("t6_busy", 32'(rx_busy), 32'd0);
    chk("t6_ferr", 32'(rx_frame_err), 32'd0);
    rst_n = 1'b1;
    rx_data = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_no_strobe", 32'(sq.size()), 32'd0);
    send_frame(8'h42, 1'b1, 1'b1, 32'd16, 2'b01, 11, tf);
    expect_strobe("t6b", 8'h42, exp_perr(2'b01, 8'h42, 1'b1), 1'b0, exp_time(tf, 16), tg);

    // Random frames: payload, parity scheme, period (including floored values) and slot value.
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      set = 2'($urandom_range(3, 0));
      cfg = 32'($urandom_range(12, 0));
      p   = ($urandom_range(1, 0) == 1) ? good_p(set, d) : ~good_p(set, d);
      gap = $urandom_range(3, 0);
      n   = eff_n(cfg);
      repeat (gap) @(negedge clk);
      send_frame(d, p, 1'b1, cfg, set, 11, tf);
      expect_strobe($sformatf("rnd%0d", k), d, exp_perr(set, d, p), 1'b0, exp_time(tf, n), tg);
    end

    repeat (20) @(negedge clk);
    chk("end_no_extra", 32'(sq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
